// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch-predictor update sequencer.
package bp_pkg;

  // Index/GHR width that the queue-entry layout is built for.
  localparam int unsigned BP_GHR_SIZE = 8;

  // 2-bit saturating counter encodings.
  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  typedef enum logic {
    StInit,
    StRun
  } bp_state_e;

  // One in-flight predicted branch.
  typedef struct packed {
    logic [BP_GHR_SIZE-1:0] index;
    logic                   pred;
    logic [BP_GHR_SIZE-1:0] ghr;
  } bp_entry_t;

  // Saturating counter step towards the resolved direction.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    end else begin
      return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    end
  endfunction

endpackage

// File: rtl/bp_update_ctrl_if.sv
// Fetch / resolve / table / redirect signals of bp_update_ctrl.
// BP_UPD_STATS_EN adds the retire and mispredict statistics outputs.
interface bp_update_ctrl_if #(
  parameter int unsigned GHR_SIZE = 8
);
  logic                i_F_valid;
  logic [GHR_SIZE-1:0] i_F_index;
  logic                i_F_pred;
  logic [GHR_SIZE-1:0] i_F_ghr;
  logic                o_F_ready;
  logic                i_R_valid;
  logic                i_R_outcome;
  logic                o_Tbl_rd_en;
  logic [GHR_SIZE-1:0] o_Tbl_rd_index;
  logic [1:0]          i_Tbl_rd_data;
  logic                o_Tbl_we;
  logic [GHR_SIZE-1:0] o_Tbl_wr_index;
  logic [1:0]          o_Tbl_wr_data;
  logic                o_Redirect;
  logic [GHR_SIZE-1:0] o_Ghr_restore;
  logic                o_Init_done;
  logic                o_Err;
`ifdef BP_UPD_STATS_EN
  logic [15:0]         o_Stat_branches;
  logic [15:0]         o_Stat_mispredicts;
`endif

  // Controller side.
  modport master (
`ifdef BP_UPD_STATS_EN
    output o_Stat_branches, o_Stat_mispredicts,
`endif
    input  i_F_valid, i_F_index, i_F_pred, i_F_ghr, i_R_valid, i_R_outcome, i_Tbl_rd_data,
    output o_F_ready, o_Tbl_rd_en, o_Tbl_rd_index, o_Tbl_we, o_Tbl_wr_index, o_Tbl_wr_data,
    output o_Redirect, o_Ghr_restore, o_Init_done, o_Err
  );

  // Fetch / ALU / table environment side.
  modport slave (
`ifdef BP_UPD_STATS_EN
    input  o_Stat_branches, o_Stat_mispredicts,
`endif
    output i_F_valid, i_F_index, i_F_pred, i_F_ghr, i_R_valid, i_R_outcome, i_Tbl_rd_data,
    input  o_F_ready, o_Tbl_rd_en, o_Tbl_rd_index, o_Tbl_we, o_Tbl_wr_index, o_Tbl_wr_data,
    input  o_Redirect, o_Ghr_restore, o_Init_done, o_Err
  );
endinterface

// File: rtl/bp_inflight_fifo.sv
// Circular FIFO of in-flight branches with whole-queue flush.
module bp_inflight_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 17
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);
  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign do_push = push && (count_q != (PtrW+1)'(DEPTH));
  assign do_pop  = pop && (count_q != '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];

  // Pointers and occupancy; flush drops every entry at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/bp_update_ctrl.sv
// Branch-prediction counter update sequencer: in-flight queue, 2-stage table
// read-modify-write with write-to-read forwarding, mispredict redirect.
// BP_UPD_STATS_EN adds saturating retire/mispredict counters.
// GHR_SIZE must match bp_pkg::BP_GHR_SIZE, which fixes the entry layout.
module bp_update_ctrl
  import bp_pkg::*;
#(
  parameter int unsigned GHR_SIZE = BP_GHR_SIZE,
  parameter int unsigned DEPTH    = 4
) (
  input logic              i_Clk,
  input logic              i_Reset_n,
  bp_update_ctrl_if.master bus
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  bp_state_e           state_q, state_d;
  logic                init_we_q, init_we_d;
  logic [GHR_SIZE-1:0] init_idx_q, init_idx_d;

  logic [CntW-1:0]     count;
  bp_entry_t           head, push_entry;
  logic                ready, retire, mispredict, push;

  logic                u1_valid_q, u1_outcome_q;
  logic [GHR_SIZE-1:0] u1_index_q;
  logic                u2_valid_q, u2_outcome_q;
  logic [GHR_SIZE-1:0] u2_index_q;
  logic                fwd_valid_q;
  logic [1:0]          fwd_data_q;
  logic [1:0]          ctr_src, u2_wr_data;
  logic                redirect_q, err_q;
  logic [GHR_SIZE-1:0] ghr_restore_q;

  assign ready      = (state_q == StRun) && (count < CntW'(DEPTH));
  assign retire     = bus.i_R_valid && (state_q == StRun) && (count != '0);
  assign mispredict = retire && (bus.i_R_outcome != head.pred);
  // A mispredict makes anything fetched this cycle wrong-path too.
  assign push       = bus.i_F_valid && ready && !mispredict;
  assign push_entry = '{index: bus.i_F_index, pred: bus.i_F_pred, ghr: bus.i_F_ghr};

  bp_inflight_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(bp_entry_t))
  ) u_fifo (
    .clk       (i_Clk),
    .rst_n     (i_Reset_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (retire),
    .flush     (mispredict),
    .count     (count),
    .head      (head)
  );

  // State register and table-init walker.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q    <= StInit;
      init_we_q  <= 1'b0;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_we_q  <= init_we_d;
      init_idx_q <= init_idx_d;
    end
  end

  // INIT walks every index once, then hands over to RUN.
  always_comb begin
    state_d    = state_q;
    init_we_d  = init_we_q;
    init_idx_d = init_idx_q;
    unique case (state_q)
      StInit: begin
        if (!init_we_q) begin
          init_we_d = 1'b1;
        end else if (init_idx_q == '1) begin
          init_we_d = 1'b0;
          state_d   = StRun;
        end else begin
          init_idx_d = init_idx_q + GHR_SIZE'(1);
        end
      end
      StRun: begin
        state_d = StRun;
      end
      default: state_d = StInit;
    endcase
  end

  // U1/U2 pipeline, forwarding capture, redirect and error flag.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      u1_valid_q    <= 1'b0;
      u1_outcome_q  <= 1'b0;
      u1_index_q    <= '0;
      u2_valid_q    <= 1'b0;
      u2_outcome_q  <= 1'b0;
      u2_index_q    <= '0;
      fwd_valid_q   <= 1'b0;
      fwd_data_q    <= 2'b00;
      redirect_q    <= 1'b0;
      ghr_restore_q <= '0;
      err_q         <= 1'b0;
    end else begin
      u1_valid_q <= retire;
      if (retire) begin
        u1_index_q   <= head.index;
        u1_outcome_q <= bus.i_R_outcome;
      end
      u2_valid_q   <= u1_valid_q;
      u2_index_q   <= u1_index_q;
      u2_outcome_q <= u1_outcome_q;
      // The BRAM returns pre-write data when U1 reads what U2 is writing.
      fwd_valid_q  <= u1_valid_q && u2_valid_q && (u1_index_q == u2_index_q);
      fwd_data_q   <= u2_wr_data;
      redirect_q   <= mispredict;
      ghr_restore_q <= mispredict ? ((head.ghr << 1) | GHR_SIZE'(bus.i_R_outcome)) : '0;
      err_q        <= err_q || (bus.i_R_valid && !retire);
    end
  end

  // Table write mux: init fill or U2 counter update.
  always_comb begin
    ctr_src    = fwd_valid_q ? fwd_data_q : bus.i_Tbl_rd_data;
    u2_wr_data = sat_update(ctr_src, u2_outcome_q);
    bus.o_Tbl_we       = init_we_q || u2_valid_q;
    bus.o_Tbl_wr_index = init_we_q ? init_idx_q : u2_index_q;
    if (init_we_q) begin
      bus.o_Tbl_wr_data = CTR_WT;
    end else if (u2_valid_q) begin
      bus.o_Tbl_wr_data = u2_wr_data;
    end else begin
      bus.o_Tbl_wr_data = 2'b00;
    end
  end

  assign bus.o_F_ready      = ready;
  assign bus.o_Tbl_rd_en    = u1_valid_q;
  assign bus.o_Tbl_rd_index = u1_index_q;
  assign bus.o_Redirect     = redirect_q;
  assign bus.o_Ghr_restore  = ghr_restore_q;
  assign bus.o_Init_done    = (state_q == StRun);
  assign bus.o_Err          = err_q;

`ifdef BP_UPD_STATS_EN
  logic [15:0] stat_br_q, stat_mp_q;

  // Saturating retire and mispredict counters.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (retire && (stat_br_q != 16'hFFFF))     stat_br_q <= stat_br_q + 16'd1;
      if (mispredict && (stat_mp_q != 16'hFFFF)) stat_mp_q <= stat_mp_q + 16'd1;
    end
  end

  assign bus.o_Stat_branches    = stat_br_q;
  assign bus.o_Stat_mispredicts = stat_mp_q;
`endif
endmodule

// File: doc/bp_update_ctrl.md
# bp_update_ctrl

Sequencer for the branch-prediction counter table. It tracks in-flight predicted branches between fetch and ALU resolution. It schedules the read-modify-write of the 2-bit saturating counters through a synchronous (BRAM) table port, and drives global-history recovery and redirect on a mispredict. It sits beside the predictor table: fetch pushes, the ALU retires, and this block owns the table's write side.

## Interface
- GHR_SIZE, 8, table index and GHR width; the table has 2**GHR_SIZE entries
- DEPTH, 4, in-flight queue entries (power of 2, ≥2)

- i_Clk  in  1  clock
- i_Reset_n  in  1  asynchronous, active-low reset
- i_F_valid  in  1  fetch issued a prediction for a branch
- i_F_index  in  GHR_SIZE  table index used for that prediction
- i_F_pred  in  1  predicted direction (1 = taken)
- i_F_ghr  in  GHR_SIZE  GHR snapshot before that prediction's shift
- o_F_ready  out  1  queue can accept; fetch stalls when low
- i_R_valid  in  1  ALU resolved the oldest in-flight branch
- i_R_outcome  in  1  actual direction
- o_Tbl_rd_en  out  1  table read request
- o_Tbl_rd_index  out  GHR_SIZE  read address (data returns next cycle)
- i_Tbl_rd_data  in  2  counter read data
- o_Tbl_we  out  1  table write enable
- o_Tbl_wr_index  out  GHR_SIZE  write address
- o_Tbl_wr_data  out  2  write data
- o_Redirect  out  1  one-cycle mispredict pulse
- o_Ghr_restore  out  GHR_SIZE  corrected GHR, valid with o_Redirect
- o_Init_done  out  1  table initialisation finished
- o_Err  out  1  sticky: resolution arrived with queue empty

## Operation
- FSM states: INIT and RUN. Reset enters INIT.
- INIT: write 2'b10 (weakly taken) to indices 0 .. 2**GHR_SIZE-1, one index per cycle, with o_F_ready=0. After the last write, go to RUN and set o_Init_done=1.
- Queue: FIFO of {index, pred, ghr}.
  - Push on i_F_valid && o_F_ready.
  - o_F_ready = RUN && count<DEPTH. It is computed from the registered count, so a full queue refuses a push even in a cycle where it also pops.
- Retire, at cycle T with i_R_valid: pop the head. Mispredict = i_R_outcome != head.pred.
- Update pipeline, stage U1 (T+1): o_Tbl_rd_en=1, o_Tbl_rd_index=head.index. Register {index, outcome}.
- Update pipeline, stage U2 (T+2): o_Tbl_we=1, o_Tbl_wr_index=index, o_Tbl_wr_data=sat(ctr, outcome).
  - Taken: ctr==3 ? 3 : ctr+1.
  - Not taken: ctr==0 ? 0 : ctr-1.
  - Arithmetic is 2-bit with no wrap.
- Forwarding: when U2 writes index X in the same cycle that U1 reads X, the next U2 uses the value just written, not i_Tbl_rd_data. This allows one resolution per cycle with no stall.
- Mispredict at T:
  - Flush the whole queue at the T edge. All remaining entries are wrong-path.
  - Discard any push in cycle T.
  - At T+1: o_Redirect=1 and o_Ghr_restore={head.ghr[GHR_SIZE-2:0], i_R_outcome}.
  - The counter update for the mispredicted branch still proceeds normally.
- i_R_valid with queue empty: ignored (no table access) and o_Err set. o_Err clears only on reset.
- i_R_valid in INIT: treated as empty-queue, so o_Err is set.

## Timing
- Reset values: o_F_ready=0, o_Tbl_rd_en=0, o_Tbl_we=0, o_Tbl_rd_index=0, o_Tbl_wr_index=0, o_Tbl_wr_data=0, o_Redirect=0, o_Ghr_restore=0, o_Init_done=0, o_Err=0.
- INIT lasts exactly 2**GHR_SIZE cycles after reset deassertion; o_F_ready rises in the following cycle.
- Retire-to-write latency is 2 cycles. Retire-to-redirect latency is 1 cycle.
- Queue pointers wrap modulo DEPTH. Count is held in log2(DEPTH)+1 bits.
- Reset asserted mid-operation aborts the U1/U2 stages (no write), empties the queue, and re-runs INIT.

## Configuration
- BP_UPD_STATS_EN defined: adds two outputs, o_Stat_branches and o_Stat_mispredicts (16 bits each).
  - They count valid retires and mispredicts respectively.
  - Each saturates at 16'hFFFF and resets to 0.
- BP_UPD_STATS_EN undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package bp_pkg holds:
  - the counter constants (CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3);
  - the INIT/RUN state enum;
  - the queue-entry typedef;
  - the saturating-update function.
- Sub-module bp_inflight_fifo (parameterised DEPTH and entry width) provides push, pop, flush, count, and head.

## Test plan
- Reset then idle:
  - 256 cycles of o_Tbl_we with wr_data=2, indices 0..255 in order.
  - o_F_ready=1 on cycle 257 and o_Init_done=1.
- Push index 0x12, pred=1; resolve outcome=1 with the counter read as 2:
  - write 0x12←3 at T+2;
  - no o_Redirect.
- Push 0x05 pred=1 and 0x06 pred=1; resolve 0x05 with outcome=0:
  - o_Redirect at T+1 with o_Ghr_restore={ghr[6:0],0};
  - queue empty, so a resolve at T+1 sets o_Err;
  - write 0x05←1 from read value 2.
- Back-to-back resolves of the same index 0x40 (counter 3), outcomes 0,0:
  - writes 2 then 1, showing forwarding.
- Push 4 entries without resolving:
  - o_F_ready=0, and a 5th i_F_valid is dropped.
  - Resolve and push in the same cycle: the queue accepts nothing that cycle.
- Counter at 0 with outcome 0 must stay 0; counter at 3 with outcome 1 must stay 3.
- Assert reset during U1: no write follows, and INIT restarts from index 0.
